apb_gpio_slave: RTL and testbench
=================================

// Module: apb_gpio_slave
// PURPOSE
//  APB3 slave GPIO register block on one PSEL line of the AHB-to-APB bridge, in the HCLK domain.
//  Holds output data and per-pin output enable, samples pins through a 2-FF synchroniser,
//  and raises a level interrupt on per-pin rising/falling edges.
//  Optional wait states. PSLVERR on illegal accesses.
// PARAMETERS
//  GPIO_WIDTH   16  number of pins, 1..32; register bits above GPIO_WIDTH read 0, ignore writes
//  WAIT_STATES  0   PREADY-low cycles inserted in the access phase, 0..15
//  TPD          1   output assignment delay (#TPD), simulation only
// PORTS
//  HCLK      in   1           clock (shared with the bridge)
//  HRESET    in   1           asynchronous reset, active-high
//  PSEL      in   1           slave select (one bit of the bridge PSEL bus)
//  PENABLE   in   1           APB access phase
//  PWRITE    in   1           1=write, 0=read
//  PADDR     in   32          byte address; only PADDR[4:0] decoded
//  PWDATA    in   32          write data
//  PRDATA    out  32          read data; valid when PSEL&PENABLE&PREADY&!PWRITE, else 0
//  PREADY    out  1           transfer complete
//  PSLVERR   out  1           error; valid only when PREADY=1
//  GPIO_IN   in   GPIO_WIDTH  asynchronous pin inputs
//  GPIO_OUT  out  GPIO_WIDTH  output data register
//  GPIO_OE   out  GPIO_WIDTH  output enable (1 = drive)
//  IRQ       out  1           |(IRQ_STAT & IRQ_EN), registered
// BEHAVIOUR
//  Reset: all registers clear; GPIO_OUT=0, GPIO_OE=0, IRQ=0, PRDATA=0, PSLVERR=0, wait counter=0.
//  Register map (word offsets):
//   0x00 DOUT RW; 0x04 OE RW; 0x08 DIN RO (synchronised pins)
//   0x0C IRQ_EN RW; 0x10 IRQ_STAT W1C; 0x14 IRQ_POL RW (1=rising, 0=falling)
//  Error response (PSLVERR=1):
//   PADDR[1:0]!=0, offset>0x14, or a write to DIN.
//   On error: no register changes; PRDATA=0.
//  State machine:
//   IDLE   -> SETUP   when PSEL&!PENABLE.
//   SETUP  -> ACCESS  on the next cycle; the wait counter loads 0.
//   ACCESS -> IDLE    on completion, or SETUP if PSEL&!PENABLE is seen again.
//  PREADY = PSEL&PENABLE&(wcnt==WAIT_STATES), combinational. Otherwise PREADY=0.
//   wcnt increments each ACCESS cycle while PREADY=0.
//   WAIT_STATES=0 gives a 2-cycle APB transfer.
//  Write commit: on the HCLK edge where PSEL&PENABLE&PREADY&PWRITE&!err.
//   No commit in SETUP or in wait cycles.
//  Read data: a combinational mux of the current registers, gated by PSEL&PENABLE&PREADY.
//  Input path: GPIO_IN -> 2 flops (DIN) -> 1 delay flop (DIN_D).
//   rise = DIN&~DIN_D; fall = ~DIN&DIN_D.
//   An edge reaches IRQ_STAT 3 cycles after the pin changes, and IRQ 1 cycle later.
//  IRQ_STAT[i] set condition: (IRQ_POL[i] ? rise[i] : fall[i]).
//   Edges set IRQ_STAT regardless of IRQ_EN; IRQ_EN only masks IRQ.
//  Set and W1C on the same bit in the same cycle: set wins.
//  PSEL dropped mid-access: the FSM returns to IDLE, no commit, wcnt cleared.
//  HRESET mid-transfer: the transfer is abandoned; all state clears immediately (async).
//  PSLVERR is driven combinationally from the decode while PREADY=1, else 0.
// STRUCTURE
//  Package apb_gpio_pkg:
//   register offset localparams (DOUT..IRQ_POL)
//   FSM state encoding: IDLE=0, SETUP=1, ACCESS=2
//   data width constant 32
//  Sub-module gpio_in_sync: per-bit 2-FF synchroniser, delay flop, rise/fall outputs.
//  Top holds: FSM, wait counter, address decode/error, registers, read mux, IRQ flop.
// TESTING
//  1 Reset with pins toggling -> all outputs 0, IRQ_STAT=0 after reset release.
//  2 WAIT_STATES=0: write 0xA5A5 to 0x00, then read 0x00.
//    -> GPIO_OUT=0xA5A5 one cycle after the access edge; read returns 0x0000A5A5.
//    -> PREADY high in the first ACCESS cycle.
//  3 WAIT_STATES=3: write 0x00FF to 0x04.
//    -> PREADY low for 3 ACCESS cycles, high on the 4th.
//    -> GPIO_OE=0x00FF only after that cycle.
//  4 Illegal accesses: read 0x18, write 0x08, write 0x02.
//    -> PSLVERR=1 with PREADY; PRDATA=0; register values unchanged.
//  5 IRQ_POL=0x0001, IRQ_EN=0x0001; GPIO_IN[0] 0->1.
//    -> IRQ_STAT[0]=1 three cycles later, IRQ=1 one cycle after that.
//    -> Write 0x1 to 0x10 clears IRQ_STAT and IRQ.
//    -> A 1->0 pin change does not set IRQ_STAT.
//  6 W1C of bit0 in the same cycle as a new rising edge on bit0 -> IRQ_STAT[0] stays 1.
//    Assert HRESET during a wait state -> PREADY=0, no commit, state cleared.

Source files
------------

// File: rtl/apb_gpio_slave_pkg.sv
// rtl/apb_gpio_slave_pkg.sv - register map, FSM encoding and decode helper for the APB GPIO slave
package apb_gpio_pkg;

  localparam int DATA_W = 32;

  localparam logic [4:0] OFF_DOUT     = 5'h00;
  localparam logic [4:0] OFF_OE       = 5'h04;
  localparam logic [4:0] OFF_DIN      = 5'h08;
  localparam logic [4:0] OFF_IRQ_EN   = 5'h0C;
  localparam logic [4:0] OFF_IRQ_STAT = 5'h10;
  localparam logic [4:0] OFF_IRQ_POL  = 5'h14;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  // Misaligned, past the last register, or a write to the read-only pin register.
  function automatic logic addr_err(input logic [4:0] off, input logic wr);
    return (off[1:0] != 2'b00) || (off > OFF_IRQ_POL) || (wr && (off == OFF_DIN));
  endfunction

endpackage

// File: rtl/apb_gpio_slave_if.sv
// rtl/apb_gpio_slave_if.sv - APB3 bus bundle between the bridge and the GPIO slave
interface apb_gpio_slave_if;

  logic                            PSEL;
  logic                            PENABLE;
  logic                            PWRITE;
  logic [apb_gpio_pkg::DATA_W-1:0] PADDR;
  logic [apb_gpio_pkg::DATA_W-1:0] PWDATA;
  logic [apb_gpio_pkg::DATA_W-1:0] PRDATA;
  logic                            PREADY;
  logic                            PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/gpio_in_sync.sv
// rtl/gpio_in_sync.sv - per-pin two-flop synchroniser plus one delay flop for edge detection
module gpio_in_sync #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] pin_async,
  output logic [W-1:0] din,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);

  logic [W-1:0] meta_q, meta_d;
  logic [W-1:0] sync_q, sync_d;
  logic [W-1:0] dly_q,  dly_d;

  always_comb begin
    meta_d = pin_async;
    sync_d = meta_q;
    dly_d  = sync_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
      dly_q  <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      dly_q  <= dly_d;
    end
  end

  assign din  = sync_q;
  assign rise = sync_q & ~dly_q;
  assign fall = ~sync_q & dly_q;

endmodule

// File: rtl/apb_gpio_slave.sv
// rtl/apb_gpio_slave.sv - APB3 GPIO register block: data/enable registers, synchronised inputs, edge IRQ
module apb_gpio_slave
  import apb_gpio_pkg::*;
#(
  parameter int GPIO_WIDTH  = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  apb_gpio_slave_if.slave       apb,
  input  logic [GPIO_WIDTH-1:0] GPIO_IN,
  output logic [GPIO_WIDTH-1:0] GPIO_OUT,
  output logic [GPIO_WIDTH-1:0] GPIO_OE,
  output logic                  IRQ
);

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  logic [1:0]            state_q, state_d;
  logic [3:0]            wcnt_q, wcnt_d;
  logic [GPIO_WIDTH-1:0] dout_q, dout_d;
  logic [GPIO_WIDTH-1:0] oe_q, oe_d;
  logic [GPIO_WIDTH-1:0] irq_en_q, irq_en_d;
  logic [GPIO_WIDTH-1:0] irq_stat_q, irq_stat_d;
  logic [GPIO_WIDTH-1:0] irq_pol_q, irq_pol_d;
  logic                  irq_q, irq_d;

  logic [4:0]            off;
  logic                  access, ready, err, commit;
  logic [GPIO_WIDTH-1:0] wdata, din, rise, fall, w1c, set, rd_reg;
  logic [DATA_W-1:0]     prdata;
  logic                  unused_bits;

  gpio_in_sync #(.W(GPIO_WIDTH)) u_sync (
    .clk       (HCLK),
    .rst       (HRESET),
    .pin_async (GPIO_IN),
    .din       (din),
    .rise      (rise),
    .fall      (fall)
  );

  assign off    = apb.PADDR[4:0];
  assign wdata  = apb.PWDATA[GPIO_WIDTH-1:0];
  assign access = apb.PSEL & apb.PENABLE;
  assign ready  = access & (wcnt_q == WS);
  assign err    = addr_err(off, apb.PWRITE);
  assign commit = ready & apb.PWRITE & ~err;

  // wcnt only advances once a setup phase has been seen, so a dropped PSEL restarts the count.
  always_comb begin
    state_d = state_q;
    wcnt_d  = '0;
    case (state_q)
      ST_IDLE: begin
        if (apb.PSEL && !apb.PENABLE) state_d = ST_SETUP;
      end
      ST_SETUP, ST_ACCESS: begin
        if (!apb.PSEL) begin
          state_d = ST_IDLE;
        end else if (!apb.PENABLE) begin
          state_d = ST_SETUP;
        end else if (ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ACCESS;
          wcnt_d  = wcnt_q + 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign w1c = (commit && (off == OFF_IRQ_STAT)) ? wdata : '0;
  assign set = (irq_pol_q & rise) | (~irq_pol_q & fall);

  always_comb begin
    dout_d     = dout_q;
    oe_d       = oe_q;
    irq_en_d   = irq_en_q;
    irq_pol_d  = irq_pol_q;
    irq_stat_d = (irq_stat_q & ~w1c) | set;
    irq_d      = |(irq_stat_q & irq_en_q);
    if (commit) begin
      case (off)
        OFF_DOUT:    dout_d    = wdata;
        OFF_OE:      oe_d      = wdata;
        OFF_IRQ_EN:  irq_en_d  = wdata;
        OFF_IRQ_POL: irq_pol_d = wdata;
        default:     ;
      endcase
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q    <= ST_IDLE;
      wcnt_q     <= '0;
      dout_q     <= '0;
      oe_q       <= '0;
      irq_en_q   <= '0;
      irq_stat_q <= '0;
      irq_pol_q  <= '0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      dout_q     <= dout_d;
      oe_q       <= oe_d;
      irq_en_q   <= irq_en_d;
      irq_stat_q <= irq_stat_d;
      irq_pol_q  <= irq_pol_d;
      irq_q      <= irq_d;
    end
  end

  always_comb begin
    rd_reg = '0;
    case (off)
      OFF_DOUT:     rd_reg = dout_q;
      OFF_OE:       rd_reg = oe_q;
      OFF_DIN:      rd_reg = din;
      OFF_IRQ_EN:   rd_reg = irq_en_q;
      OFF_IRQ_STAT: rd_reg = irq_stat_q;
      OFF_IRQ_POL:  rd_reg = irq_pol_q;
      default:      rd_reg = '0;
    endcase
  end

  always_comb begin
    prdata = '0;
    if (ready && !apb.PWRITE && !err) prdata[GPIO_WIDTH-1:0] = rd_reg;
  end

  assign apb.PRDATA  = prdata;
  assign apb.PREADY  = ready;
  assign apb.PSLVERR = ready & err;

  assign GPIO_OUT = dout_q;
  assign GPIO_OE  = oe_q;
  assign IRQ      = irq_q;

  assign unused_bits = ^{apb.PADDR[DATA_W-1:5], apb.PWDATA};

endmodule

// File: tb/tb_apb_gpio_slave.sv
// tb/tb_apb_gpio_slave.sv - directed and randomised checks of two GPIO slaves (0 and 3 wait states)
module tb_apb_gpio_slave;

  localparam int WS0 = 0;
  localparam int WS1 = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  psel;
  logic        penable, pwrite;
  logic [31:0] paddr, pwdata, rd;
  logic [15:0] gpio_in;

  wire [1:0][15:0] gout, goe;
  wire [1:0]       irq, pready, pslverr;
  wire [1:0][31:0] prdata;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: register contents and an IRQ_STAT/IRQ view built from pin sample history.
  logic [15:0] m_dout[2], m_oe[2], m_en[2], m_pol[2], m_stat[2], w1c_pend[2];
  logic        m_irq[2];
  logic [15:0] pin_1ago, pin_2ago, pin_3ago;

  apb_gpio_slave_if bus0();
  apb_gpio_slave_if bus1();

  assign bus0.PSEL = psel[0];  assign bus1.PSEL = psel[1];
  assign bus0.PENABLE = penable;  assign bus1.PENABLE = penable;
  assign bus0.PWRITE = pwrite;  assign bus1.PWRITE = pwrite;
  assign bus0.PADDR = paddr;  assign bus1.PADDR = paddr;
  assign bus0.PWDATA = pwdata;  assign bus1.PWDATA = pwdata;
  assign pready  = {bus1.PREADY, bus0.PREADY};
  assign pslverr = {bus1.PSLVERR, bus0.PSLVERR};
  assign prdata  = {bus1.PRDATA, bus0.PRDATA};

  apb_gpio_slave #(.GPIO_WIDTH(16), .WAIT_STATES(WS0)) dut0 (
    .HCLK(clk), .HRESET(rst), .apb(bus0.slave), .GPIO_IN(gpio_in),
    .GPIO_OUT(gout[0]), .GPIO_OE(goe[0]), .IRQ(irq[0])
  );

  apb_gpio_slave #(.GPIO_WIDTH(16), .WAIT_STATES(WS1)) dut1 (
    .HCLK(clk), .HRESET(rst), .apb(bus1.slave), .GPIO_IN(gpio_in),
    .GPIO_OUT(gout[1]), .GPIO_OE(goe[1]), .IRQ(irq[1])
  );

  always #5 clk = ~clk;

  // An edge counts when the pin sampled three edges ago differs from the one two edges ago.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pin_1ago <= '0;
      pin_2ago <= '0;
      pin_3ago <= '0;
      for (int d = 0; d < 2; d++) begin
        m_stat[d] <= '0;
        m_irq[d]  <= 1'b0;
      end
    end else begin
      pin_1ago <= gpio_in;
      pin_2ago <= pin_1ago;
      pin_3ago <= pin_2ago;
      for (int d = 0; d < 2; d++) begin
        m_irq[d]  <= |(m_stat[d] & m_en[d]);
        m_stat[d] <= (m_stat[d] & ~w1c_pend[d])
                   | (m_pol[d] & pin_2ago & ~pin_3ago)
                   | (~m_pol[d] & ~pin_2ago & pin_3ago);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input int d, input logic [4:0] off);
    case (off)
      5'h00:   return {16'h0, m_dout[d]};
      5'h04:   return {16'h0, m_oe[d]};
      5'h08:   return {16'h0, pin_2ago};
      5'h0C:   return {16'h0, m_en[d]};
      5'h10:   return {16'h0, m_stat[d]};
      5'h14:   return {16'h0, m_pol[d]};
      default: return 32'h0;
    endcase
  endfunction

  task automatic clear_model();
    for (int d = 0; d < 2; d++) begin
      m_dout[d] = '0; m_oe[d] = '0; m_en[d] = '0; m_pol[d] = '0; w1c_pend[d] = '0;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      check("irq0_idle", 32'(irq[0]), 32'(m_irq[0]));
      check("irq1_idle", 32'(irq[1]), 32'(m_irq[1]));
      @(posedge clk); #1;
    end
  endtask

  task automatic apb(input int d, input bit wr, input logic [31:0] addr,
                     input logic [31:0] wdata, output logic [31:0] rdata);
    int ws;
    logic err;
    logic [4:0] off;
    ws  = (d == 0) ? WS0 : WS1;
    off = addr[4:0];
    err = (addr[1:0] != 2'b00) || (off > 5'h14) || (wr && off == 5'h08);
    rdata = '0;
    psel[d] = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
    @(negedge clk);
    check("pready_setup", 32'(pready[d]), 32'h0);
    @(posedge clk); #1;
    penable = 1'b1;
    for (int i = 0; i <= ws; i++) begin
      if (i == ws && wr && !err && off == 5'h10) w1c_pend[d] = wdata[15:0];
      @(negedge clk);
      check("pready", 32'(pready[d]), 32'(i == ws));
      check("pslverr", 32'(pslverr[d]), 32'((i == ws) && err));
      check("gpio_out_hold", 32'(gout[d]), 32'(m_dout[d]));
      check("gpio_oe_hold", 32'(goe[d]), 32'(m_oe[d]));
      check("irq_xfer", 32'(irq[d]), 32'(m_irq[d]));
      if (i == ws) begin
        rdata = prdata[d];
        check("prdata", rdata, (wr || err) ? 32'h0 : model_read(d, off));
      end
      @(posedge clk); #1;
    end
    w1c_pend[d] = '0;
    if (wr && !err) begin
      case (off)
        5'h00:   m_dout[d] = wdata[15:0];
        5'h04:   m_oe[d]   = wdata[15:0];
        5'h0C:   m_en[d]   = wdata[15:0];
        5'h14:   m_pol[d]  = wdata[15:0];
        default: ;
      endcase
    end
    psel[d] = 1'b0; penable = 1'b0;
    check("gpio_out_after", 32'(gout[d]), 32'(m_dout[d]));
    check("gpio_oe_after", 32'(goe[d]), 32'(m_oe[d]));
  endtask

  initial begin
    rst = 1'b1; psel = '0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0; gpio_in = '0;
    clear_model();

    // Reset held while pins toggle
    repeat (4) begin
      @(posedge clk); #1;
      gpio_in = 16'($urandom);
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_gpio_out", 32'(gout[d]), 32'h0);
      check("rst_gpio_oe", 32'(goe[d]), 32'h0);
      check("rst_irq", 32'(irq[d]), 32'h0);
      check("rst_pready", 32'(pready[d]), 32'h0);
      check("rst_pslverr", 32'(pslverr[d]), 32'h0);
      check("rst_prdata", prdata[d], 32'h0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    tick(3);
    apb(0, 1'b0, 32'h10, 32'h0, rd); check("rst_irq_stat0", rd, 32'h0);
    apb(1, 1'b0, 32'h10, 32'h0, rd); check("rst_irq_stat1", rd, 32'h0);

    // Zero-wait write/read of DOUT
    apb(0, 1'b1, 32'h00, 32'h0000A5A5, rd);
    check("dout_written", 32'(gout[0]), 32'h0000A5A5);
    apb(0, 1'b0, 32'h00, 32'h0, rd);
    check("dout_read", rd, 32'h0000A5A5);

    // Three wait states on OE
    apb(1, 1'b1, 32'h04, 32'h000000FF, rd);
    check("oe_written", 32'(goe[1]), 32'h000000FF);

    // Illegal accesses
    apb(0, 1'b0, 32'h18, 32'h0, rd); check("err_read_prdata", rd, 32'h0);
    apb(0, 1'b1, 32'h08, 32'hFFFF, rd);
    apb(0, 1'b1, 32'h02, 32'hFFFF, rd);
    check("err_dout_kept", 32'(gout[0]), 32'h0000A5A5);
    apb(0, 1'b0, 32'h00, 32'h0, rd); check("err_dout_read", rd, 32'h0000A5A5);

    // Rising-edge interrupt on pin 0
    gpio_in = '0; tick(4);
    apb(0, 1'b1, 32'h10, 32'hFFFF, rd);
    apb(0, 1'b1, 32'h14, 32'h0001, rd);
    apb(0, 1'b1, 32'h0C, 32'h0001, rd);
    tick(1);
    gpio_in[0] = 1'b1;
    tick(2);
    check("edge_irq_pre", 32'(irq[0]), 32'h0);
    apb(0, 1'b0, 32'h10, 32'h0, rd);
    check("edge_stat_set", rd, 32'h1);
    check("edge_irq_set", 32'(irq[0]), 32'h1);
    apb(0, 1'b1, 32'h10, 32'h1, rd);
    tick(1);
    check("w1c_irq_clear", 32'(irq[0]), 32'h0);
    apb(0, 1'b0, 32'h10, 32'h0, rd); check("w1c_stat_clear", rd, 32'h0);
    gpio_in[0] = 1'b0; tick(5);
    apb(0, 1'b0, 32'h10, 32'h0, rd); check("fall_ignored", rd, 32'h0);

    // W1C coinciding with a new rising edge: set wins
    gpio_in[0] = 1'b1; tick(1);
    apb(0, 1'b1, 32'h10, 32'h1, rd);
    apb(0, 1'b0, 32'h10, 32'h0, rd); check("set_beats_w1c", rd, 32'h1);

    // Reset during a wait state
    psel[1] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h04; pwdata = 32'hF0F0;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("wait_pready_low", 32'(pready[1]), 32'h0);
    rst = 1'b1;
    #1;
    clear_model();
    check("arst_pready", 32'(pready[1]), 32'h0);
    check("arst_oe", 32'(goe[1]), 32'h0);
    check("arst_dout", 32'(gout[0]), 32'h0);
    check("arst_irq", 32'(irq[0]), 32'h0);
    psel = '0; penable = 1'b0;
    @(posedge clk); #1;
    tick(1);
    rst = 1'b0;
    tick(2);
    check("arst_no_commit", 32'(goe[1]), 32'h0);
    apb(1, 1'b0, 32'h04, 32'h0, rd); check("arst_oe_read", rd, 32'h0);

    // Randomised traffic against the reference model
    for (int n = 0; n < 150; n++) begin
      int d, a;
      bit wr;
      logic [31:0] addr;
      d  = int'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      a  = int'($urandom_range(0, 9));
      addr = (a < 8) ? 32'(a * 4) : 32'($urandom_range(0, 31));
      addr = addr | ($urandom & 32'hFFFF_FFE0);
      if ($urandom_range(0, 1) == 1) gpio_in = 16'($urandom);
      apb(d, wr, addr, $urandom, rd);
      tick(int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
